// File: rtl/pwm_ramp_ctrl_if.sv
// Register-write port of the PWM ramp controller.
// The master drives one channel configuration per accepted write.
interface pwm_ramp_ctrl_if;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [15:0] wr_freq;
   logic [6:0]  wr_duty;
   logic [7:0]  wr_rate;
   logic        wr_ready;

   modport master (
      output wr_en,
      output wr_ch,
      output wr_freq,
      output wr_duty,
      output wr_rate,
      input  wr_ready
   );

   modport slave (
      input  wr_en,
      input  wr_ch,
      input  wr_freq,
      input  wr_duty,
      input  wr_rate,
      output wr_ready
   );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Frequency/duty configuration for a 4-channel PWM bank. Duty writes set a target,
// and a tick-driven round-robin scan walks each channel's duty toward it by one step.
module pwm_ramp_ctrl #(
   parameter int unsigned STEP_DIV = 1000
) (
   input  logic          mclk,
   input  logic          reset,
   pwm_ramp_ctrl_if.slave wr,
   output logic [15:0]   pwm_freq1,
   output logic [15:0]   pwm_freq2,
   output logic [15:0]   pwm_freq3,
   output logic [15:0]   pwm_freq4,
   output logic [6:0]    pwm_duty1,
   output logic [6:0]    pwm_duty2,
   output logic [6:0]    pwm_duty3,
   output logic [6:0]    pwm_duty4,
   output logic [3:0]    busy
);

   localparam logic [15:0] TICK_LAST = 16'(STEP_DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN0 = 3'd1,
      SCAN1 = 3'd2,
      SCAN2 = 3'd3,
      SCAN3 = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic        wr_ready_q, wr_ready_d;
   logic        tick_s;
   logic        visit_en_s;
   logic [1:0]  visit_ch_s;
   logic        wr_acc_s;

   logic [15:0] freq_q[4],     freq_d[4];
   logic [6:0]  target_q[4],   target_d[4];
   logic [6:0]  duty_q[4],     duty_d[4];
   logic [7:0]  rate_q[4],     rate_d[4];
   logic [7:0]  rate_cnt_q[4], rate_cnt_d[4];

   function automatic logic [6:0] clamp_duty(input logic [6:0] d);
      return (d > 7'd100) ? 7'd100 : d;
   endfunction

   // Scheduler tick divider
   always_comb begin
      tick_s = (tick_cnt_q == TICK_LAST);
      if (tick_s) begin
         tick_cnt_d = 16'd0;
      end else begin
         tick_cnt_d = tick_cnt_q + 16'd1;
      end
   end

   // Scan FSM: one channel visited per cycle after each tick
   always_comb begin
      state_d    = state_q;
      visit_en_s = 1'b0;
      visit_ch_s = 2'd0;
      case (state_q)
         IDLE: begin
            if (tick_s) begin
               state_d = SCAN0;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN0: begin
            visit_en_s = 1'b1;
            visit_ch_s = 2'd0;
            state_d    = SCAN1;
         end
         SCAN1: begin
            visit_en_s = 1'b1;
            visit_ch_s = 2'd1;
            state_d    = SCAN2;
         end
         SCAN2: begin
            visit_en_s = 1'b1;
            visit_ch_s = 2'd2;
            state_d    = SCAN3;
         end
         SCAN3: begin
            visit_en_s = 1'b1;
            visit_ch_s = 2'd3;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      wr_ready_d = (state_d == IDLE);
   end

   // wr_ready_q tracks state_q == IDLE, so writes and visits never coincide
   assign wr_acc_s = wr.wr_en & wr_ready_q;

   // Per-channel configuration writes and ramp stepping
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         freq_d[c]     = freq_q[c];
         target_d[c]   = target_q[c];
         duty_d[c]     = duty_q[c];
         rate_d[c]     = rate_q[c];
         rate_cnt_d[c] = rate_cnt_q[c];
         if (wr_acc_s && (wr.wr_ch == 2'(c))) begin
            freq_d[c]     = wr.wr_freq;
            target_d[c]   = clamp_duty(wr.wr_duty);
            rate_d[c]     = wr.wr_rate;
            rate_cnt_d[c] = 8'd0;
         end else if (visit_en_s && (visit_ch_s == 2'(c))) begin
            if (duty_q[c] == target_q[c]) begin
               rate_cnt_d[c] = 8'd0;
            end else if (rate_q[c] == 8'd0) begin
               duty_d[c] = target_q[c];
            end else if ((rate_cnt_q[c] + 8'd1) >= rate_q[c]) begin
               if (target_q[c] > duty_q[c]) begin
                  duty_d[c] = duty_q[c] + 7'd1;
               end else begin
                  duty_d[c] = duty_q[c] - 7'd1;
               end
               rate_cnt_d[c] = 8'd0;
            end else begin
               rate_cnt_d[c] = rate_cnt_q[c] + 8'd1;
            end
         end else begin
            rate_cnt_d[c] = rate_cnt_q[c];
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge mclk) begin
      if (reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= 16'd0;
         wr_ready_q <= 1'b1;
         for (int c = 0; c < 4; c++) begin
            freq_q[c]     <= 16'd0;
            target_q[c]   <= 7'd0;
            duty_q[c]     <= 7'd0;
            rate_q[c]     <= 8'd0;
            rate_cnt_q[c] <= 8'd0;
         end
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         wr_ready_q <= wr_ready_d;
         for (int c = 0; c < 4; c++) begin
            freq_q[c]     <= freq_d[c];
            target_q[c]   <= target_d[c];
            duty_q[c]     <= duty_d[c];
            rate_q[c]     <= rate_d[c];
            rate_cnt_q[c] <= rate_cnt_d[c];
         end
      end
   end

   assign wr.wr_ready = wr_ready_q;
   assign pwm_freq1   = freq_q[0];
   assign pwm_freq2   = freq_q[1];
   assign pwm_freq3   = freq_q[2];
   assign pwm_freq4   = freq_q[3];
   assign pwm_duty1   = duty_q[0];
   assign pwm_duty2   = duty_q[1];
   assign pwm_duty3   = duty_q[2];
   assign pwm_duty4   = duty_q[3];
   assign busy        = {(duty_q[3] != target_q[3]), (duty_q[2] != target_q[2]),
                         (duty_q[1] != target_q[1]), (duty_q[0] != target_q[0])};

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus random writes,
// every cycle compared against a cycle-count based reference model.
module tb_pwm_ramp_ctrl;
   localparam int S = 8;

   logic        mclk;
   logic        reset;
   logic [15:0] f1, f2, f3, f4;
   logic [6:0]  d1, d2, d3, d4;
   logic [3:0]  busy_o;

   pwm_ramp_ctrl_if wr_if ();

   pwm_ramp_ctrl #(.STEP_DIV(S)) dut (
      .mclk      (mclk),
      .reset     (reset),
      .wr        (wr_if),
      .pwm_freq1 (f1),
      .pwm_freq2 (f2),
      .pwm_freq3 (f3),
      .pwm_freq4 (f4),
      .pwm_duty1 (d1),
      .pwm_duty2 (d2),
      .pwm_duty3 (d3),
      .pwm_duty4 (d4),
      .busy      (busy_o)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: m_cyc = edges since reset; tick occurs on the edge where
   // m_cyc % S == S-1, then channel c is visited on the edge where m_cyc % S == c.
   int m_cyc;
   int m_freq[4];
   int m_target[4];
   int m_duty[4];
   int m_rate[4];
   int m_rcnt[4];

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_ready(input int cyc);
      return !((cyc >= S) && ((cyc % S) < 4));
   endfunction

   task automatic model_clear();
      m_cyc = 0;
      for (int c = 0; c < 4; c++) begin
         m_freq[c] = 0; m_target[c] = 0; m_duty[c] = 0; m_rate[c] = 0; m_rcnt[c] = 0;
      end
   endtask

   task automatic model_visit(input int c);
      if (m_duty[c] == m_target[c]) begin
         m_rcnt[c] = 0;
      end else if (m_rate[c] == 0) begin
         m_duty[c] = m_target[c];
      end else if (m_rcnt[c] + 1 >= m_rate[c]) begin
         m_duty[c] = m_duty[c] + ((m_target[c] > m_duty[c]) ? 1 : -1);
         m_rcnt[c] = 0;
      end else begin
         m_rcnt[c] = m_rcnt[c] + 1;
      end
   endtask

   task automatic compare_all();
      int fo[4];
      int dd[4];
      fo = '{int'(f1), int'(f2), int'(f3), int'(f4)};
      dd = '{int'(d1), int'(d2), int'(d3), int'(d4)};
      check_eq("wr_ready", int'(wr_if.wr_ready), int'(model_ready(m_cyc)));
      for (int c = 0; c < 4; c++) begin
         check_eq($sformatf("freq%0d", c + 1), fo[c], m_freq[c]);
         check_eq($sformatf("duty%0d", c + 1), dd[c], m_duty[c]);
         check_eq($sformatf("busy%0d", c), int'(busy_o[c]), int'(m_duty[c] != m_target[c]));
      end
   endtask

   // One clock: update the model from the pre-edge inputs, then compare #1 later
   task automatic run_cycle();
      int pre;
      pre = m_cyc;
      @(posedge mclk);
      if (reset) begin
         model_clear();
      end else begin
         if (wr_if.wr_en && model_ready(pre)) begin
            m_freq[wr_if.wr_ch]   = int'(wr_if.wr_freq);
            m_target[wr_if.wr_ch] = (wr_if.wr_duty > 7'd100) ? 100 : int'(wr_if.wr_duty);
            m_rate[wr_if.wr_ch]   = int'(wr_if.wr_rate);
            m_rcnt[wr_if.wr_ch]   = 0;
         end
         if ((pre >= S) && ((pre % S) < 4)) model_visit(pre % S);
         m_cyc = pre + 1;
      end
      #1;
      compare_all();
   endtask

   task automatic do_write(input int ch, input int fr, input int du, input int ra);
      wr_if.wr_en   = 1'b1;
      wr_if.wr_ch   = 2'(ch);
      wr_if.wr_freq = 16'(fr);
      wr_if.wr_duty = 7'(du);
      wr_if.wr_rate = 8'(ra);
      run_cycle();
      wr_if.wr_en   = 1'b0;
   endtask

   task automatic wait_after_scan();
      run_cycle();
      while ((m_cyc % S) != 4) run_cycle();
   endtask

   // Count ticks until busy[ch] drops; compare to |delta| * max(rate,1)
   task automatic ramp_watch(input int ch, input int exp_ticks);
      int ticks;
      int n;
      int limit;
      ticks = 0;
      n     = 0;
      limit = exp_ticks * S * 2 + 50;
      while (busy_o[ch] && (n < limit)) begin
         if ((m_cyc % S) == S - 1) ticks++;
         run_cycle();
         n++;
      end
      check_eq($sformatf("ramp_in_time_ch%0d", ch), int'(n < limit), 1);
      check_eq($sformatf("ramp_ticks_ch%0d", ch), ticks, exp_ticks);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      wr_if.wr_en = 1'b0; wr_if.wr_ch = 2'd0; wr_if.wr_freq = 16'd0;
      wr_if.wr_duty = 7'd0; wr_if.wr_rate = 8'd0;
      model_clear();

      // Reset, then idle for three tick periods
      reset = 1'b1;
      run_cycle();
      run_cycle();
      reset = 1'b0;
      check_eq("rst_busy", int'(busy_o), 0);
      check_eq("rst_ready", int'(wr_if.wr_ready), 1);
      for (int i = 0; i < 3 * S; i++) run_cycle();

      // Ramp up ch0 to 10 at rate 1
      wait_after_scan();
      do_write(0, 500, 10, 1);
      check_eq("freq1_latency", int'(f1), 500);
      check_eq("busy0_set", int'(busy_o[0]), 1);
      ramp_watch(0, 10);
      check_eq("ramp_up_final", int'(d1), 10);

      // Jump with clamp, then slow ramp down by 3 at rate 3
      wait_after_scan();
      do_write(3, 777, 120, 0);
      ramp_watch(3, 1);
      check_eq("clamp_duty4", int'(d4), 100);
      wait_after_scan();
      do_write(3, 777, 97, 3);
      ramp_watch(3, 9);
      check_eq("down_duty4", int'(d4), 97);

      // Write issued during SCAN1 must be dropped
      n = 0;
      while (!((m_cyc >= S) && ((m_cyc % S) == 1)) && (n < 4 * S)) begin
         run_cycle();
         n++;
      end
      do_write(1, 1234, 50, 5);
      check_eq("drop_freq2", int'(f2), 0);
      check_eq("drop_busy1", int'(busy_o[1]), 0);

      // Reverse mid-ramp on ch2
      wait_after_scan();
      do_write(2, 300, 40, 2);
      n = 0;
      while ((m_duty[2] != 6) && (n < 40 * S)) begin
         run_cycle();
         n++;
      end
      check_eq("reverse_reached6", int'(d3), 6);
      wait_after_scan();
      do_write(2, 300, 0, 2);
      ramp_watch(2, 12);
      check_eq("reverse_final", int'(d3), 0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         wr_if.wr_en   = ($urandom_range(0, 3) == 0);
         wr_if.wr_ch   = 2'($urandom_range(0, 3));
         wr_if.wr_freq = 16'($urandom);
         wr_if.wr_duty = 7'($urandom_range(0, 127));
         wr_if.wr_rate = 8'($urandom_range(0, 3));
         run_cycle();
      end
      wr_if.wr_en = 1'b0;

      // Reset while all four channels ramp
      wait_after_scan();
      for (int c = 0; c < 4; c++) do_write(c, 100 + c, 100, 1);
      for (int i = 0; i < 3 * S; i++) run_cycle();
      check_eq("pre_reset_busy", int'(busy_o), 15);
      reset = 1'b1;
      run_cycle();
      reset = 1'b0;
      check_eq("midrst_busy", int'(busy_o), 0);
      check_eq("midrst_duty", int'({d1, d2, d3, d4}), 0);
      for (int i = 0; i < 3 * S; i++) run_cycle();
      check_eq("post_reset_duty", int'({d1, d2, d3, d4}), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Configuration and duty-ramp scheduler for the 4-channel PWM bank. It sits between a simple register-write port and the `pwm_freq1..4` / `pwm_duty1..4` inputs of the PWM top level. Frequency writes are applied directly. Duty writes set a target, and a time-multiplexed scheduler steps each channel's duty by ±1 toward its target at a per-channel rate. This gives soft-start and soft-stop on all four outputs.

## Interface

**Parameters**
- `STEP_DIV`, default 1000: mclk cycles per scheduler tick. Legal range is 8..65535.

**Ports**
- `mclk`  in  1  main clock; single clock domain.
- `reset`  in  1  main reset, synchronous, active-high.
- `wr_en`  in  1  write strobe; sampled only while `wr_ready`=1.
- `wr_ch`  in  2  channel select; 0..3 map to channels 1..4.
- `wr_freq`  in  16  period value, forwarded to `pwm_freqN`.
- `wr_duty`  in  7  target duty in percent; values >100 clamp to 100.
- `wr_rate`  in  8  ticks per duty step; 0 means jump immediately.
- `wr_ready`  out  1  write port available; low while the scheduler scans.
- `pwm_freq1..4`  out  16 each  registered frequency to PWM channel.
- `pwm_duty1..4`  out  7 each  registered ramped duty to PWM channel.
- `busy`  out  4  bit n = channel n+1 duty ≠ target.

## Operation

- **Tick counter:** 16-bit, counts 0..STEP_DIV-1 and wraps. `tick` is asserted for one cycle when count = STEP_DIV-1.
- **FSM states:** IDLE, SCAN0, SCAN1, SCAN2, SCAN3.
  - IDLE→SCAN0 on `tick`. SCANk→SCANk+1 unconditionally. SCAN3→IDLE.
  - Exactly one channel is visited per cycle. STEP_DIV ≥ 8 guarantees the scan completes before the next tick.
- **`wr_ready`:** 1 in IDLE, 0 in SCAN0..3. A write with `wr_en`=1 while `wr_ready`=0 is dropped. No queueing.
- **Accepted write** to channel c:
  - `freq_c`←`wr_freq`.
  - `target_c`←min(`wr_duty`,100).
  - `rate_c`←`wr_rate`.
  - `rate_cnt_c`←0.
  - The current duty is untouched, so a retarget mid-ramp continues from the present duty.
- **Visit of channel c in SCANk:**
  - If duty_c = target_c: `rate_cnt_c`←0.
  - Else, if `rate_c`=0: duty_c←target_c.
  - Else, if `rate_cnt_c`+1 ≥ `rate_c`: duty_c ±1 toward target, and `rate_cnt_c`←0.
  - Else: `rate_cnt_c`+1.
- **Arithmetic:** duty is unsigned 7-bit and never leaves 0..100, because stepping is always toward a clamped target. `rate_cnt` is 8-bit and cannot overflow because it resets at `rate_c`.
- **`busy[n]`:** combinational compare of registered duty_n and target_n.
- **Reset mid-operation:** all state is cleared on the next edge, the FSM returns to IDLE, and any ramp in progress is abandoned.

## Timing

- **Reset values:**
  - `pwm_freq1..4`=0, `pwm_duty1..4`=0, `busy`=0, `wr_ready`=1.
  - Tick counter=0; FSM=IDLE.
  - targets=0, rates=0, rate_cnt=0.
- **Write latency:**
  - Write accepted at edge E. `pwm_freqN` is valid after E, i.e. a 1-cycle latency.
  - `busy` reflects the new target after E.
- **Duty update:** the duty of channel c changes at the edge that ends SCANc. SCAN0 starts the cycle after `tick`, so channel 1 updates 2 edges after the tick cycle begins, and channel 4 updates 5 edges after.
- **Ramp duration:** |target−duty| × max(`rate`,1) ticks; for `rate`=0, one tick.
- **Write and tick together:** a write in the same cycle as `tick` (FSM still IDLE) is accepted. The following scan uses the new target.
- **Same-cycle write and visit:** impossible, because `wr_ready`=0 during scans.

## Test plan

- **Reset:** assert `reset` for 2 cycles → all outputs are 0, `wr_ready`=1, `busy`=0. Then hold idle for 3×STEP_DIV → outputs are unchanged.
- **Ramp up:** STEP_DIV=8; write ch0 freq=500, duty=10, rate=1 → `pwm_freq1`=500 after 1 cycle; `busy[0]`=1; `pwm_duty1` steps 1..10, one per tick; reaches 10 after 10 ticks; `busy[0]`=0 on the next cycle.
- **Jump and clamp:** write ch3 duty=120, rate=0 → `pwm_duty4`=100 at the end of SCAN3 of the first tick. Rate=3 from duty 100 to 97 → 9 ticks.
- **Dropped write:** pulse `wr_en` during SCAN1 with ch1 duty=50 → write ignored; `pwm_freq2`/target unchanged; `busy[1]`=0.
- **Reverse mid-ramp:** ch2 ramping 0→40 at rate=2; at duty=6 write target 0 → duty counts down from 6 and reaches 0 after 12 ticks.
- **Reset mid-ramp:** assert `reset` while 4 channels are ramping → all duties and `busy` are 0 on the next edge, and no further steps occur.
